// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types and constants for the two-port ROM arbiter.
// The round-robin policy is enabled by defining ROM_ARB_RR_EN.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    READ    = 2'd2,
    CAPTURE = 2'd3
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_ID0 = 1'b0;
  localparam req_id_t REQ_ID1 = 1'b1;

  // Edges from grant to valid data: SETUP, READ, CAPTURE
  localparam int ARB_ACCESS_CYCLES = 3;

endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: requester-side handshake bus of the ROM arbiter.
// master = requesters (drive req/adr), slave = arbiter (drives gnt/vld/rdata/busy).
interface rom_arbiter_if #(
  parameter int ROM_DATASIZE = 8,
  parameter int ROM_ADRSIZE  = 5
);

  logic                    req0;
  logic                    req1;
  logic [ROM_ADRSIZE-1:0]  adr0;
  logic [ROM_ADRSIZE-1:0]  adr1;
  logic                    gnt0;
  logic                    gnt1;
  logic                    vld0;
  logic                    vld1;
  logic [ROM_DATASIZE-1:0] rdata;
  logic                    busy;

  modport master (
    output req0, req1, adr0, adr1,
    input  gnt0, gnt1, vld0, vld1, rdata, busy
  );

  modport slave (
    input  req0, req1, adr0, adr1,
    output gnt0, gnt1, vld0, vld1, rdata, busy
  );

endinterface

// File: rtl/rom_arb_pick.sv
// rom_arb_pick: combinational winner selection between the two requesters.
// With ROM_ARB_RR_EN defined, a "last served" pointer breaks ties in favour of
// the other port; otherwise port 0 always wins a tie and no state exists.
module rom_arb_pick
  import rom_arb_pkg::*;
(
`ifdef ROM_ARB_RR_EN
  input  logic    clk,
  input  logic    rst_n,
  input  logic    take,
`endif
  input  logic    req0,
  input  logic    req1,
  output logic    win_any,
  output req_id_t win_id
);

`ifdef ROM_ARB_RR_EN
  req_id_t last_q;

  // Remember who was granted last; reset value makes port 0 win the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_ID1;
    end else if (take) begin
      last_q <= win_id;
    end
  end

  // Tie goes to the port not served last; a lone requester always wins
  always_comb begin
    win_any = req0 | req1;
    win_id  = REQ_ID0;
    if (req0 && req1) begin
      win_id = (last_q == REQ_ID1) ? REQ_ID0 : REQ_ID1;
    end else if (req1) begin
      win_id = REQ_ID1;
    end
  end
`else
  // Fixed priority: port 1 wins only when port 0 is not requesting
  always_comb begin
    win_any = req0 | req1;
    win_id  = (!req0 && req1) ? REQ_ID1 : REQ_ID0;
  end
`endif

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one single-port ROM between two requesters using a
// fixed IDLE -> SETUP -> READ -> CAPTURE sequence per access.
// Define ROM_ARB_RR_EN for round-robin ties; default is fixed priority (port 0).
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ROM_DATASIZE = 8,
  parameter int ROM_ADRSIZE  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rom_arbiter_if.slave            bus,
  output logic [ROM_ADRSIZE-1:0]  rom_adr,
  output logic                    rom_oe,
  output logic                    rom_cs,
  input  logic [ROM_DATASIZE-1:0] rom_data
);

  arb_state_t              state_q;
  arb_state_t              state_d;
  logic                    take;
  logic                    busy;
  logic                    win_any;
  req_id_t                 win_id;
  req_id_t                 owner_q;
  logic                    gnt0_q;
  logic                    gnt1_q;
  logic                    vld0_q;
  logic                    vld1_q;
  logic [ROM_DATASIZE-1:0] rdata_q;

  rom_arb_pick u_pick (
`ifdef ROM_ARB_RR_EN
    .clk     (clk),
    .rst_n   (rst_n),
    .take    (take),
`endif
    .req0    (bus.req0),
    .req1    (bus.req1),
    .win_any (win_any),
    .win_id  (win_id)
  );

  // State register; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and ROM strobes decoded from the current state
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    rom_cs  = 1'b1;
    rom_oe  = 1'b0;
    busy    = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (win_any) begin
          take    = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        rom_cs  = 1'b0;
        state_d = READ;
      end
      READ: begin
        rom_cs  = 1'b0;
        rom_oe  = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant/valid pulses, latched address and owner, and the captured word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
      owner_q <= REQ_ID0;
      rom_adr <= '0;
      rdata_q <= '0;
    end else begin
      gnt0_q <= take && (win_id == REQ_ID0);
      gnt1_q <= take && (win_id == REQ_ID1);
      vld0_q <= (state_q == CAPTURE) && (owner_q == REQ_ID0);
      vld1_q <= (state_q == CAPTURE) && (owner_q == REQ_ID1);
      if (take) begin
        rom_adr <= (win_id == REQ_ID1) ? bus.adr1 : bus.adr0;
        owner_q <= win_id;
      end
      if (state_q == CAPTURE) begin
        rdata_q <= rom_data;
      end
    end
  end

  assign bus.gnt0  = gnt0_q;
  assign bus.gnt1  = gnt1_q;
  assign bus.vld0  = vld0_q;
  assign bus.vld1  = vld1_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed bench for rom_arbiter with a behavioural ROM that
// loads its output on the rising edge of OE while CS is low.
// Tie expectations follow ROM_ARB_RR_EN when it is defined.
module tb_rom_arbiter;
  import rom_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rom_adr;
  logic       rom_oe;
  logic       rom_cs;
  logic [7:0] rom_data;
  logic [7:0] mem [32];
  int         oe_rises = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  rom_arbiter_if #(.ROM_DATASIZE(8), .ROM_ADRSIZE(5)) bus ();

  rom_arbiter #(.ROM_DATASIZE(8), .ROM_ADRSIZE(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .rom_adr  (rom_adr),
    .rom_oe   (rom_oe),
    .rom_cs   (rom_cs),
    .rom_data (rom_data)
  );

  // ROM model: an OE rising edge with CS low loads the addressed word
  always @(posedge rom_oe) begin
    oe_rises++;
    if (!rom_cs) rom_data = mem[rom_adr];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic r0, input logic [4:0] a0, input logic r1, input logic [4:0] a1);
    bus.req0 = r0;
    bus.adr0 = a0;
    bus.req1 = r1;
    bus.adr1 = a1;
  endtask

  // {gnt0, gnt1, vld0, vld1}
  task automatic expect_flags(input string tag, input logic [3:0] exp);
    check_output(tag, {28'd0, bus.gnt0, bus.gnt1, bus.vld0, bus.vld1}, {28'd0, exp});
  endtask

  // {rom_cs, rom_oe, busy}
  task automatic expect_rom(input string tag, input logic [2:0] exp);
    check_output(tag, {29'd0, rom_cs, rom_oe, bus.busy}, {29'd0, exp});
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] exp_data [3];
    int         oe_base;
    logic       exp_id;

    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0]  = 8'h3C;
    mem[1]  = 8'hC3;
    mem[2]  = 8'h5A;
    mem[3]  = 8'h11;
    mem[5]  = 8'hA5;
    mem[31] = 8'hEE;
    exp_data[0] = 8'h3C;
    exp_data[1] = 8'hC3;
    exp_data[2] = 8'h5A;
    apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0);

    // Reset state
    tick();
    expect_rom("reset_rom", 3'b100);
    expect_flags("reset_flags", 4'b0000);
    check_output("reset_adr", {27'd0, rom_adr}, 32'd0);
    check_output("reset_rdata", {24'd0, bus.rdata}, 32'd0);
    rst_n = 1'b1;

    // Single read from port 0, address 5
    $display("[TB] single read port 0");
    apply_stimulus(1'b1, 5'd5, 1'b0, 5'd0);
    tick();
    expect_flags("t1_gnt", 4'b1000);
    expect_rom("t1_setup", 3'b001);
    check_output("t1_adr", {27'd0, rom_adr}, 32'd5);
    apply_stimulus(1'b0, 5'd5, 1'b0, 5'd0);
    tick();
    expect_flags("t1_read_flags", 4'b0000);
    expect_rom("t1_read", 3'b011);
    tick();
    expect_rom("t1_capture", 3'b101);
    expect_flags("t1_capture_flags", 4'b0000);
    tick();
    expect_flags("t1_vld", 4'b0010);
    check_output("t1_rdata", {24'd0, bus.rdata}, 32'h0000_00A5);
    expect_rom("t1_idle", 3'b100);
    tick();
    expect_flags("t1_vld_pulse", 4'b0000);
    check_output("t1_rdata_hold", {24'd0, bus.rdata}, 32'h0000_00A5);

    // Both ports held together
    $display("[TB] tie between ports");
    do_reset();
    apply_stimulus(1'b1, 5'd3, 1'b1, 5'd31);
    for (int k = 0; k < 4; k++) begin
`ifdef ROM_ARB_RR_EN
      exp_id = k[0];
`else
      exp_id = 1'b0;
`endif
      tick();
      expect_flags($sformatf("tie_gnt%0d", k), exp_id ? 4'b0100 : 4'b1000);
      repeat (ARB_ACCESS_CYCLES - 1) tick();
      tick();
      expect_flags($sformatf("tie_vld%0d", k), exp_id ? 4'b0001 : 4'b0010);
      check_output($sformatf("tie_rdata%0d", k), {24'd0, bus.rdata},
                   exp_id ? 32'h0000_00EE : 32'h0000_0011);
    end
    apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    expect_rom("tie_idle", 3'b100);

    // Only port 1 at the top address
    $display("[TB] port 1 max address");
    apply_stimulus(1'b0, 5'd0, 1'b1, 5'd31);
    tick();
    expect_flags("t3_gnt", 4'b0100);
    check_output("t3_adr", {27'd0, rom_adr}, 32'd31);
    apply_stimulus(1'b0, 5'd0, 1'b0, 5'd31);
    tick();
    expect_flags("t3_read", 4'b0000);
    tick();
    expect_flags("t3_capture", 4'b0000);
    tick();
    expect_flags("t3_vld", 4'b0001);
    check_output("t3_rdata", {24'd0, bus.rdata}, 32'h0000_00EE);

    // Reset asserted during READ
    $display("[TB] reset during read");
    tick();
    apply_stimulus(1'b1, 5'd2, 1'b0, 5'd0);
    tick();
    expect_flags("t4_gnt", 4'b1000);
    apply_stimulus(1'b0, 5'd2, 1'b0, 5'd0);
    tick();
    expect_rom("t4_read", 3'b011);
    #1 rst_n = 1'b0;
    #1;
    expect_rom("t4_async_rom", 3'b100);
    expect_flags("t4_async_flags", 4'b0000);
    check_output("t4_async_adr", {27'd0, rom_adr}, 32'd0);
    check_output("t4_async_rdata", {24'd0, bus.rdata}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_flags($sformatf("t4_no_vld%0d", k), 4'b0000);
    end
    apply_stimulus(1'b1, 5'd2, 1'b0, 5'd0);
    tick();
    expect_flags("t4_regnt", 4'b1000);
    apply_stimulus(1'b0, 5'd2, 1'b0, 5'd0);
    repeat (ARB_ACCESS_CYCLES) tick();
    expect_flags("t4_revld", 4'b0010);
    check_output("t4_rerdata", {24'd0, bus.rdata}, 32'h0000_005A);

    // Short REQ0 pulse while port 1 is being served
    $display("[TB] dropped request");
    tick();
    oe_base = oe_rises;
    apply_stimulus(1'b0, 5'd0, 1'b1, 5'd31);
    tick();
    expect_flags("t5_gnt1", 4'b0100);
    apply_stimulus(1'b1, 5'd0, 1'b0, 5'd31);
    tick();
    expect_flags("t5_busy_a", 4'b0000);
    apply_stimulus(1'b0, 5'd0, 1'b0, 5'd31);
    tick();
    expect_flags("t5_busy_b", 4'b0000);
    tick();
    expect_flags("t5_vld1", 4'b0001);
    tick();
    expect_flags("t5_no_gnt0", 4'b0000);
    expect_rom("t5_idle", 3'b100);
    tick();
    check_output("t5_rom_accesses", oe_rises - oe_base, 32'd1);

    // Back-to-back port 0 reads over addresses 0, 1, 2
    $display("[TB] back-to-back port 0");
    apply_stimulus(1'b1, 5'd0, 1'b0, 5'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_flags($sformatf("b2b_gnt%0d", k), 4'b1000);
      apply_stimulus(1'b1, 5'(k + 1), 1'b0, 5'd0);
      tick();
      tick();
      tick();
      expect_flags($sformatf("b2b_vld%0d", k), 4'b0010);
      check_output($sformatf("b2b_rdata%0d", k), {24'd0, bus.rdata}, {24'd0, exp_data[k]});
      if (k == 2) apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0);
    end
    tick();
    expect_rom("b2b_idle", 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares one single-port `rom` instance (active-low CS, OE-high read, read triggered on OE/ADR change) between two requesters, e.g. instruction fetch (port 0) and data load (port 1) of the RISC-V core. Each access is sequenced as a fixed three-cycle transaction: drive the address with OE low, raise OE, then register the ROM output. Results are returned to the winning requester with a one-cycle valid pulse. Arbitration is round-robin or fixed priority, selected at compile time.

## Interface
- ROM_DATASIZE, 8, ROM data width
- ROM_ADRSIZE, 5, ROM address width
- CLK  in  1  single clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- REQ0 / REQ1  in  1  read request, held until matching GNT
- ADR0 / ADR1  in  ROM_ADRSIZE  request address, stable while REQ high
- GNT0 / GNT1  out  1  one-cycle pulse: request accepted, ADR sampled
- VLD0 / VLD1  out  1  one-cycle pulse: RDATA holds this requester's word
- RDATA  out  ROM_DATASIZE  registered read data, shared by both requesters
- BUSY  out  1  high in every state except IDLE
- ROM_ADR  out  ROM_ADRSIZE  to rom ADR
- ROM_OE  out  1  to rom OE
- ROM_CS  out  1  to rom CS (active-low)
- ROM_DATA  in  ROM_DATASIZE  from rom DATA1

## Operation
- FSM states: IDLE, SETUP, READ, CAPTURE. Transitions are unconditional except from IDLE.
- IDLE: ROM_CS=1, ROM_OE=0. If any REQ is high at the edge, pick a winner, register its ADR into ROM_ADR and its ID into an owner register, pulse its GNT, and go to SETUP. Otherwise stay in IDLE.
- SETUP: ROM_CS=0, ROM_OE=0, ROM_ADR stable. Go to READ.
- READ: ROM_CS=0, ROM_OE=1. The OE rising edge causes the rom to load ROM_DATA. Go to CAPTURE.
- CAPTURE: at entry, RDATA <= ROM_DATA and the owner's VLD pulses. ROM_OE=0, ROM_CS=1. Go to IDLE.
- Arbitration:
  - One requester high: it wins.
  - Both high: the winner depends on the configured policy (see Configuration).
  - A REQ that drops before its GNT is never served and causes no ROM access.
- ROM_ADR holds its last value outside transactions. RDATA holds its value until the next CAPTURE.
- Addresses pass through unmodified; the full range 0..2^ROM_ADRSIZE-1 is legal. No address arithmetic, no wrap logic.
- A requester whose REQ stays high after its GNT is treated as a new request at the next IDLE.

## Timing
- Request seen at edge e0 → GNT high in cycle e0..e1.
- SETUP is e1, READ is e2, CAPTURE edge is e3 → VLD and new RDATA in cycle e3..e4.
- Latency from grant edge to valid: 3 cycles.
- Peak throughput: one access every 4 cycles (IDLE re-samples at e4).
- GNT and VLD are never both high for the same requester. At most one GNT and one VLD are high per cycle.
- Reset values: ROM_CS=1, ROM_OE=0, ROM_ADR=0, RDATA=0, GNT0/1=0, VLD0/1=0, BUSY=0, state=IDLE, round-robin pointer = "last served 1" (so port 0 wins first).
- Reset asserted mid-transaction: all outputs go to reset values immediately (asynchronously). The access is abandoned, no VLD is issued, and the requester must re-request.

## Configuration
- Macro `ROM_ARB_RR_EN`.
- Defined: round-robin. On a tie, the requester not served last wins. The pointer updates on every grant.
- Undefined: fixed priority. Port 0 always wins ties, and no pointer register exists.
- Single-requester behaviour is identical in both modes.

## Structure
- Package `rom_arb_pkg`:
  - state enum typedef `arb_state_t` (IDLE, SETUP, READ, CAPTURE)
  - requester-ID constants `REQ_ID0`/`REQ_ID1`
  - transaction length constant `ARB_ACCESS_CYCLES = 3`
- Sub-module `rom_arb_pick`: combinational winner selection plus the round-robin pointer register, which is present only under `ROM_ARB_RR_EN`.
- The top level holds the FSM, the address/owner registers and RDATA.

## Test plan
- MEM[5]=8'hA5; REQ0 with ADR0=5 → GNT0 one cycle, VLD0 exactly 3 cycles later with RDATA=8'hA5. ROM_OE rises in READ only, and ROM_CS is low only in SETUP/READ.
- REQ0 (ADR 3, MEM=8'h11) and REQ1 (ADR 31, MEM=8'hEE) held together, RR build → grants 0,1,0,1 four cycles apart with VLD0=8'h11 and VLD1=8'hEE. Fixed-priority build → GNT0 every grant.
- Only REQ1, ADR1=31 (max address) → VLD1 with MEM[31]. VLD0 and GNT0 stay low throughout.
- RST_N pulled low during READ → outputs drop to reset values the same cycle. No VLD after release. A re-request completes normally.
- REQ0 pulsed for one cycle while BUSY serving port 1, then dropped → no GNT0 and no extra ROM access.
- Back-to-back REQ0 held high across addresses 0,1,2 → VLD0 every 4 cycles with the correct data each time.
